inst_fetch_queue: RTL

- Consumer end of the program-counter address stream.
- Each cycle, takes the fetch address driven by the program counter and issues a read to the synchronous instruction ROM, which has 1-cycle read latency.
- Captures the returned instruction, tagged with its address, into a small FIFO and presents it to decode with a valid/ready handshake.
- Back-pressures the address source through fetchHold; discards all queued and in-flight work on flush (branch taken).

---
 rtl/inst_fetch_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: issues program-counter addresses to a 1-cycle synchronous
// instruction ROM and queues the returned {instruction, address} pairs for decode.
module inst_fetch_queue #(
  parameter int INST_ADDR_LEN = 8,
  parameter int INST_LEN      = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INST_ADDR_LEN-1:0] fetchAddr,
  input  logic                     fetchValid,
  input  logic                     flush,
  output logic                     fetchHold,
  output logic                     romRd,
  output logic [INST_ADDR_LEN-1:0] romAddr,
  input  logic [INST_LEN-1:0]      romData,
  output logic [INST_LEN-1:0]      instOut,
  output logic [INST_ADDR_LEN-1:0] instAddr,
  output logic                     instValid,
  input  logic                     instReady
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [INST_LEN-1:0]      inst;
    logic [INST_ADDR_LEN-1:0] addr;
  } entry_t;

  entry_t                   mem_q [DEPTH];
  entry_t                   mem_d [DEPTH];
  logic [PW:0]              count_q, count_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic                     pend_valid_q, pend_valid_d;
  logic [INST_ADDR_LEN-1:0] pend_addr_q, pend_addr_d;
  logic [PW+1:0]            occupancy;
  logic                     push, pop;

  // Issue side and head presentation; the in-flight read is counted so the
  // queue can never be overrun by data already on its way back from the ROM.
  always_comb begin
    occupancy = {1'b0, count_q} + (PW+2)'(pend_valid_q);
    fetchHold = (occupancy >= (PW+2)'(DEPTH));
    romAddr   = fetchAddr;
    romRd     = fetchValid & ~fetchHold & ~flush & ~reset;
    instValid = (count_q != '0);
    instOut   = mem_q[rd_ptr_q].inst;
    instAddr  = mem_q[rd_ptr_q].addr;
  end

  // Next-state: capture returning ROM data, pop to decode, flush wipes all.
  always_comb begin
    push         = pend_valid_q & ~flush;
    pop          = instValid & instReady & ~flush;
    mem_d        = mem_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pend_valid_d = romRd;
    pend_addr_d  = romRd ? fetchAddr : pend_addr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{inst: romData, addr: pend_addr_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      count_d      = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      pend_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; storage is cleared so the head
  // outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      mem_q        <= mem_d;
    end
  end

endmodule
